// File: rtl/slot_alloc_pkg.sv
// Shared types for the slot allocator: default-width index/count types and the stage FSM states.
package slot_alloc_pkg;

    localparam int SA_W = 32;

    typedef logic [$clog2(SA_W)-1:0]   idx_t;
    typedef logic [$clog2(SA_W+1)-1:0] cnt_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_e;

endpackage

// File: rtl/slot_alloc_e.sv
// Circular left-most-zero finder: scans x_i from pos_i-1 downward (wrapping) and ends at pos_i.
module e #(
    parameter int W       = 32,
    parameter int RADIX_N = 4
) (
    input  logic [W-1:0]         x_i,
    input  logic [$clog2(W)-1:0] pos_i,
    output logic                 any,
    output logic [$clog2(W)-1:0] y_enc
);
    localparam int IW = $clog2(W);
    localparam int G  = (W + RADIX_N - 1) / RADIX_N;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int TW = $clog2(RADIX_N);

    typedef logic [IW-1:0] loc_idx_t;
    typedef logic [GW-1:0] grp_t;
    typedef logic [TW-1:0] sub_t;

    // req[j] is set when the j-th slot in search order is free; j=0 has top priority.
    logic [W-1:0]                  req;
    logic [G-1:0][RADIX_N-1:0]     req_grp;
    logic [G-1:0]                  grp_any;
    grp_t                          sel_g;
    sub_t                          sel_t;
    logic                          g_hit;
    logic                          t_hit;

    always_comb begin
        req = '0;
        for (int j = 0; j < W; j++) begin
            req[j] = ~x_i[loc_idx_t'((int'(pos_i) + 2 * W - 1 - j) % W)];
        end
    end

    assign req_grp = (G * RADIX_N)'(req);
    assign any     = |req;

    always_comb begin
        grp_any = '0;
        sel_g   = '0;
        g_hit   = 1'b0;
        for (int g = 0; g < G; g++) begin
            grp_any[g] = |req_grp[g];
            if (!g_hit && grp_any[g]) begin
                sel_g = grp_t'(g);
                g_hit = 1'b1;
            end
        end
        sel_t = '0;
        t_hit = 1'b0;
        for (int t = 0; t < RADIX_N; t++) begin
            if (!t_hit && req_grp[sel_g][t]) begin
                sel_t = sub_t'(t);
                t_hit = 1'b1;
            end
        end
        y_enc = loc_idx_t'((int'(pos_i) + 2 * W - 1
                            - (int'(sel_g) * RADIX_N + int'(sel_t))) % W);
    end

endmodule

// File: rtl/slot_alloc.sv
// Round-robin slot allocator with a one-entry output stage; SLOT_ALLOC_ERR_EN adds a sticky err_o.
module slot_alloc
    import slot_alloc_pkg::*;
#(
    parameter int W       = 32,
    parameter int RADIX_N = 4
) (
    input  logic                   clk,
    input  logic                   arst_n,
    output logic                   alloc_vld_o,
    output logic [$clog2(W)-1:0]   alloc_idx_o,
    input  logic                   alloc_rdy_i,
    input  logic                   free_vld_i,
    input  logic [$clog2(W)-1:0]   free_idx_i,
    output logic [$clog2(W+1)-1:0] cnt_o,
    output logic                   full_o
`ifdef SLOT_ALLOC_ERR_EN
   ,output logic                   err_o
`endif
);
    localparam int IW = $clog2(W);
    localparam int CW = $clog2(W + 1);

    typedef logic [IW-1:0] sa_idx_t;
    typedef logic [CW-1:0] sa_cnt_t;

    stage_e   state_r;
    stage_e   state_nxt;
    logic [W-1:0] occ_r;
    logic [W-1:0] occ_nxt;
    sa_idx_t  ptr_r;
    sa_idx_t  out_idx_r;
    sa_idx_t  y_enc;
    sa_cnt_t  cnt_r;
    logic     any;
    logic     hs;
    logic     load;
    logic     free_ok;

    e #(
        .W       (W),
        .RADIX_N (RADIX_N)
    ) u_e (
        .x_i   (occ_r),
        .pos_i (ptr_r),
        .any   (any),
        .y_enc (y_enc)
    );

    assign hs = (state_r == FULL) && alloc_rdy_i;

    // The staged slot is marked occupied but not yet owned by anyone, so it cannot be returned.
    assign free_ok = free_vld_i && (int'(free_idx_i) < W) && occ_r[free_idx_i]
                     && !((state_r == FULL) && (free_idx_i == out_idx_r));

    always_comb begin
        state_nxt = state_r;
        load      = 1'b0;
        case (state_r)
            EMPTY: begin
                if (any) begin
                    state_nxt = FULL;
                    load      = 1'b1;
                end
            end
            FULL: begin
                if (hs) begin
                    if (any) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = EMPTY;
                    end
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // The finder sees pre-free occupancy, so a freed bit can never collide with the new grant.
    always_comb begin
        occ_nxt = occ_r;
        if (free_ok) begin
            occ_nxt[free_idx_i] = 1'b0;
        end
        if (load) begin
            occ_nxt[y_enc] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            occ_r     <= '0;
            ptr_r     <= '0;
            out_idx_r <= '0;
            cnt_r     <= '0;
        end else begin
            occ_r <= occ_nxt;
            if (load) begin
                out_idx_r <= y_enc;
                ptr_r     <= y_enc;
            end
            if (hs && !free_ok) begin
                cnt_r <= cnt_r + sa_cnt_t'(1);
            end else if (free_ok && !hs) begin
                cnt_r <= cnt_r - sa_cnt_t'(1);
            end
        end
    end

`ifdef SLOT_ALLOC_ERR_EN
    logic err_r;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            err_r <= 1'b0;
        end else if (free_vld_i && !free_ok) begin
            err_r <= 1'b1;
        end
    end

    assign err_o = err_r;
`endif

    assign alloc_vld_o = (state_r == FULL);
    assign alloc_idx_o = out_idx_r;
    assign cnt_o       = cnt_r;
    assign full_o      = &occ_r;

endmodule

// File: tb/tb_slot_alloc.sv
// Bench for slot_alloc with W=8: per-edge vector table feeding a scoreboard, plus reset corner cases.
module tb_slot_alloc;

    localparam int W  = 8;
    localparam int IW = $clog2(W);
    localparam int CW = $clog2(W + 1);
    localparam int EW = 1 + IW + CW + 1 + 1;

    logic          clk;
    logic          arst_n;
    logic          alloc_vld_o;
    logic [IW-1:0] alloc_idx_o;
    logic          alloc_rdy_i;
    logic          free_vld_i;
    logic [IW-1:0] free_idx_i;
    logic [CW-1:0] cnt_o;
    logic          full_o;
`ifdef SLOT_ALLOC_ERR_EN
    logic          err_o;
`endif

    slot_alloc #(
        .W       (W),
        .RADIX_N (4)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .alloc_vld_o (alloc_vld_o),
        .alloc_idx_o (alloc_idx_o),
        .alloc_rdy_i (alloc_rdy_i),
        .free_vld_i  (free_vld_i),
        .free_idx_i  (free_idx_i),
        .cnt_o       (cnt_o),
        .full_o      (full_o)
`ifdef SLOT_ALLOC_ERR_EN
       ,.err_o       (err_o)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          rdy;
        logic          fv;
        logic [IW-1:0] fi;
        logic          vld;
        logic [IW-1:0] idx;
        logic [CW-1:0] cnt;
        logic          full;
        logic          err;
    } row_t;

    row_t          rows[$];
    logic [EW-1:0] exp_q[$];
    int            total;
    int            bad;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic rdy, input logic fv, input int fi,
                       input logic vld, input int idx, input int cnt, input logic full,
                       input logic err);
        row_t r;
        r.rst  = rst;
        r.rdy  = rdy;
        r.fv   = fv;
        r.fi   = IW'(fi);
        r.vld  = vld;
        r.idx  = IW'(idx);
        r.cnt  = CW'(cnt);
        r.full = full;
        r.err  = err;
        rows.push_back(r);
    endtask

    task automatic check_out(input string tag, input logic [EW-1:0] e);
        logic          e_vld;
        logic [IW-1:0] e_idx;
        logic [CW-1:0] e_cnt;
        logic          e_full;
        logic          e_err;
        {e_vld, e_idx, e_cnt, e_full, e_err} = e;
        chk({tag, ".vld"}, int'(alloc_vld_o), int'(e_vld));
        if (e_vld) chk({tag, ".idx"}, int'(alloc_idx_o), int'(e_idx));
        chk({tag, ".cnt"}, int'(cnt_o), int'(e_cnt));
        chk({tag, ".full"}, int'(full_o), int'(e_full));
`ifdef SLOT_ALLOC_ERR_EN
        chk({tag, ".err"}, int'(err_o), int'(e_err));
`else
        if (e_err === 1'bx) chk({tag, ".err"}, 0, 1);
`endif
    endtask

    // driver: reset pulse, checking the reset state while it is held
    task automatic do_reset();
        arst_n      = 1'b0;
        alloc_rdy_i = 1'b0;
        free_vld_i  = 1'b0;
        free_idx_i  = '0;
        #1;
        check_out("reset", {1'b0, IW'(0), CW'(0), 1'b0, 1'b0});
        chk("reset.idx0", int'(alloc_idx_o), 0);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic run_rows(input int lo, input int hi);
        logic [EW-1:0] e;
        for (int k = lo; k <= hi; k++) begin
            @(negedge clk);
            if (rows[k].rst) do_reset();
            alloc_rdy_i = rows[k].rdy;
            free_vld_i  = rows[k].fv;
            free_idx_i  = rows[k].fi;
            exp_q.push_back({rows[k].vld, rows[k].idx, rows[k].cnt, rows[k].full, rows[k].err});
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_out($sformatf("row%0d", k), e);
            end
        end
        @(negedge clk);
        free_vld_i = 1'b0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        arst_n      = 1'b0;
        alloc_rdy_i = 1'b0;
        free_vld_i  = 1'b0;
        free_idx_i  = '0;

        // A (0-8): drain all slots in descending order, then B (9-11): free 3 and re-grant it
        add(1, 1, 0, 0, 1, 7, 0, 0, 0);
        add(0, 1, 0, 0, 1, 6, 1, 0, 0);
        add(0, 1, 0, 0, 1, 5, 2, 0, 0);
        add(0, 1, 0, 0, 1, 4, 3, 0, 0);
        add(0, 1, 0, 0, 1, 3, 4, 0, 0);
        add(0, 1, 0, 0, 1, 2, 5, 0, 0);
        add(0, 1, 0, 0, 1, 1, 6, 0, 0);
        add(0, 1, 0, 0, 1, 0, 7, 1, 0);
        add(0, 1, 0, 0, 0, 0, 8, 1, 0);
        add(0, 0, 1, 3, 0, 0, 7, 0, 0);
        add(0, 0, 0, 0, 1, 3, 7, 1, 0);
        add(0, 1, 0, 0, 0, 3, 8, 1, 0);
        // C (12-16): consumer stalls, offer holds
        for (int i = 0; i < 5; i++) add(i == 0, 0, 0, 0, 1, 7, 0, 0, 0);
        // D (17-21): free 7 alongside the handshake of 5
        add(1, 1, 0, 0, 1, 7, 0, 0, 0);
        add(0, 1, 0, 0, 1, 6, 1, 0, 0);
        add(0, 1, 0, 0, 1, 5, 2, 0, 0);
        add(0, 1, 1, 7, 1, 4, 2, 0, 0);
        add(0, 1, 0, 0, 1, 3, 3, 0, 0);
        // E (22-25): illegal frees (unallocated 2, staged 7)
        add(1, 0, 0, 0, 1, 7, 0, 0, 0);
        add(0, 0, 1, 2, 1, 7, 0, 0, 1);
        add(0, 0, 1, 7, 1, 7, 0, 0, 1);
        add(0, 0, 0, 0, 1, 7, 0, 0, 1);
        // F (26-30): four grants outstanding before an async reset
        add(1, 1, 0, 0, 1, 7, 0, 0, 0);
        add(0, 1, 0, 0, 1, 6, 1, 0, 0);
        add(0, 1, 0, 0, 1, 5, 2, 0, 0);
        add(0, 1, 0, 0, 1, 4, 3, 0, 0);
        add(0, 1, 0, 0, 1, 3, 4, 0, 0);

        run_rows(0, 11);
        run_rows(12, 16);
        chk("stall.occ", int'(dut.occ_r), 'h80);
        run_rows(17, 21);
        run_rows(22, 25);
        chk("illegal.occ", int'(dut.occ_r), 'h80);
        run_rows(26, 29);

        // last F row by hand so the reset lands mid-cycle right after the check
        alloc_rdy_i = 1'b1;
        @(posedge clk);
        #1;
        check_out("pre_async", {1'b1, IW'(3), CW'(4), 1'b0, 1'b0});
        #2;
        arst_n = 1'b0;
        #1;
        check_out("async_rst", {1'b0, IW'(0), CW'(0), 1'b0, 1'b0});
        chk("async_rst.occ", int'(dut.occ_r), 0);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        check_out("post_rst", {1'b1, IW'(7), CW'(0), 1'b0, 1'b0});

        if (exp_q.size() != 0) chk("scoreboard_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
